// File: rtl/uart_pkg.sv
// Shared UART command-path types: 24-bit command packet, opcodes and receive bit-FSM states.
// Pure type/constant package; no logic, no latency, no flow control.
package uart_pkg;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserializer: 2-flop rx synchronizer, oversampled bit FSM, LSB-first shift register.
// byte_valid/frame_err rise 1 clk after the stop-sampling tick; never stalls, no backpressure.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       start_det,
  output logic       rx_idle
);

  localparam int             CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  FULL_LAST = CW'(OVERSAMPLE - 1);

  rx_state_t     state, state_nxt;
  logic          sync1, rx_s, armed;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          cnt_clr, bit_smp, byte_done, frm_bad;

  // armed blocks a line held low across reset release from looking like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      armed <= 1'b0;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      if (sample_tick && rx_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    bit_smp   = 1'b0;
    byte_done = 1'b0;
    frm_bad   = 1'b0;
    start_det = 1'b0;
    if (sample_tick) begin
      case (state)
        IDLE: if (armed && !rx_s) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
          start_det = 1'b1;
        end
        START: if (tick_cnt == HALF_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
        DATA: if (tick_cnt == FULL_LAST) begin
          cnt_clr = 1'b1;
          bit_smp = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
        STOP: if (tick_cnt == FULL_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            byte_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            frm_bad   = 1'b1;
            state_nxt = BREAK;
          end
        end
        BREAK: if (rx_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= byte_done;
      frame_err  <= frm_bad;
      if (sample_tick) tick_cnt <= cnt_clr ? '0 : tick_cnt + CW'(1);
      if (state != DATA) bit_cnt <= '0;
      else if (bit_smp)  bit_cnt <= bit_cnt + 3'd1;
      if (bit_smp) shift <= {rx_s, shift[7:1]};
    end
  end

  assign byte_data = shift;
  assign rx_idle   = (state == IDLE);

endmodule

// File: rtl/uart_rx.sv
// UART receive front end: groups 8N1 bytes into cmd_packet_t and writes them to the command FIFO.
// cmd_wr_en rises 2 clks after the last stop-bit tick; FIFO full drops the packet with overflow_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE   = 16,
  parameter int PKT_BYTES    = 3,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic        rx,
  input  logic        cmd_fifo_full,
  output cmd_packet_t cmd_wr_data,
  output logic        cmd_wr_en,
  output logic        frame_err,
  output logic        overflow_err,
  output logic        timeout_err
);

  localparam int            TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int            TW       = $clog2(TO_TICKS + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_TICKS - 1);
  localparam logic [1:0]    LAST_IDX = 2'(PKT_BYTES - 1);

  logic [7:0]    byte_data;
  logic          byte_valid, byte_ferr, start_det, rx_idle;
  logic [1:0]    idx;
  logic [7:0]    opcode_q, addr_q;
  logic [TW-1:0] idle_cnt;
  logic          to_hit;

  uart_rx_byte #(.OVERSAMPLE(OVERSAMPLE)) u_byte (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (byte_ferr),
    .start_det  (start_det),
    .rx_idle    (rx_idle)
  );

  assign frame_err = byte_ferr;
  assign to_hit    = sample_tick && rx_idle && (idx != 2'd0) && (idle_cnt == TO_LAST);

  // framer: a frame error, a completed packet or a timeout all realign to byte 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx          <= '0;
      opcode_q     <= '0;
      addr_q       <= '0;
      cmd_wr_data  <= '0;
      cmd_wr_en    <= 1'b0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      cmd_wr_en    <= 1'b0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
      if (byte_ferr) begin
        idx <= '0;
      end else if (byte_valid) begin
        case (idx)
          2'd0:    opcode_q <= byte_data;
          2'd1:    addr_q   <= byte_data;
          default: ;
        endcase
        if (idx == LAST_IDX) begin
          idx <= '0;
          if (cmd_fifo_full) begin
            overflow_err <= 1'b1;
          end else begin
            cmd_wr_en   <= 1'b1;
            cmd_wr_data <= {opcode_q, addr_q, byte_data};
          end
        end else begin
          idx <= idx + 2'd1;
        end
      end else if (to_hit) begin
        idx         <= '0;
        timeout_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (start_det || idx == 2'd0 || to_hit) begin
      idle_cnt <= '0;
    end else if (sample_tick && rx_idle) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: byte-level packet model with an event scoreboard plus literal checks.
module tb_uart_rx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst, sample_tick, rx, cmd_fifo_full;
  logic [23:0] cmd_wr_data;
  logic        cmd_wr_en, frame_err, overflow_err, timeout_err;

  int checks = 0, passes = 0;
  int wr_cnt = 0, fe_cnt = 0, ov_cnt = 0, to_cnt = 0;

  // expected events in order: {kind, data}; kind 0=write 1=frame 2=overflow 3=timeout
  logic [25:0] exp_q[$];
  logic [23:0] hold;
  int          m_idx;
  logic [7:0]  m_b0, m_b1;

  uart_rx #(.OVERSAMPLE(16), .PKT_BYTES(3), .TIMEOUT_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .rx           (rx),
    .cmd_fifo_full(cmd_fifo_full),
    .cmd_wr_data  (cmd_wr_data),
    .cmd_wr_en    (cmd_wr_en),
    .frame_err    (frame_err),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void m_byte(input logic [7:0] b, input bit ok, input logic full);
    if (!ok) begin
      exp_q.push_back({2'd1, 24'h0});
      m_idx = 0;
      return;
    end
    case (m_idx)
      0: m_b0 = b;
      1: m_b1 = b;
      default: begin
        if (full) exp_q.push_back({2'd2, 24'h0});
        else      exp_q.push_back({2'd0, m_b0, m_b1, b});
      end
    endcase
    m_idx = (m_idx + 1) % 3;
  endfunction

  function automatic void m_timeout();
    if (m_idx != 0) exp_q.push_back({2'd3, 24'h0});
    m_idx = 0;
  endfunction

  task automatic ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!sample_tick);
    end
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit ok, input bit lat);
    m_byte(b, ok, cmd_fifo_full);
    rx = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(16);
    end
    rx = ok;
    ticks(9);
    if (lat) begin
      @(negedge clk);
      chk("lat_wr_en_1clk", {31'd0, cmd_wr_en}, 32'd0);
      @(negedge clk);
      chk("lat_wr_en_2clk", {31'd0, cmd_wr_en}, 32'd1);
    end
    ticks(7);
    if (!ok) begin
      rx = 1'b1;
      ticks(2);
    end
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, 1'b1, 1'b0);
    send(b, 1'b1, 1'b0);
    send(c, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    int          n;
    logic [1:0]  k;
    logic [25:0] got, e;
    if (!rst) begin
      hold = '0;
    end else begin
      n = int'(cmd_wr_en) + int'(frame_err) + int'(overflow_err) + int'(timeout_err);
      if (n > 1) begin
        chk("exclusive_pulses", n, 32'd1);
      end else if (n == 1) begin
        k   = cmd_wr_en ? 2'd0 : frame_err ? 2'd1 : overflow_err ? 2'd2 : 2'd3;
        got = {k, cmd_wr_en ? cmd_wr_data : 24'h0};
        case (k)
          2'd0: wr_cnt++;
          2'd1: fe_cnt++;
          2'd2: ov_cnt++;
          default: to_cnt++;
        endcase
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_event: got %0h, none expected", got);
        end else begin
          e = exp_q.pop_front();
          chk("event", {6'd0, got}, {6'd0, e});
          if (e[25:24] == 2'd0) hold = e[23:0];
        end
      end
      if (!cmd_wr_en) chk("wr_data_hold", {8'd0, cmd_wr_data}, {8'd0, hold});
    end
  end

  logic [7:0] b2b [12];
  logic [7:0] rbyte;
  int         w0;

  initial begin
    rst = 1'b0; rx = 1'b1; cmd_fifo_full = 1'b0; m_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_data", {8'd0, cmd_wr_data}, 32'd0);
    chk("rst_wr_en", {31'd0, cmd_wr_en}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overflow_err", {31'd0, overflow_err}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    rst = 1'b1;
    ticks(4);

    // single write packet with exact write latency
    send(CMD_WRITE, 1'b1, 1'b0);
    send(8'h10, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b1);
    chk("t1_data", {8'd0, cmd_wr_data}, 32'h0210A5);
    chk("t1_writes", wr_cnt, 32'd1);
    chk("t1_no_errors", fe_cnt + ov_cnt + to_cnt, 32'd0);

    // 3-tick glitch must not produce a byte or shift packet alignment
    rx = 1'b0; ticks(3); rx = 1'b1; ticks(40);
    send_pkt(CMD_READ, 8'h20, 8'h00);
    chk("t2_glitch_aligned", {8'd0, cmd_wr_data}, 32'h012000);
    send(CMD_WRITE, 1'b1, 1'b0);
    send(CMD_READ, 1'b0, 1'b0);
    chk("t2_frame_errs", fe_cnt, 32'd1);
    send_pkt(CMD_READ, 8'h20, 8'h00);
    chk("t2_writes", wr_cnt, 32'd3);
    chk("t2_data", {8'd0, cmd_wr_data}, 32'h012000);

    // FIFO full drops the packet, data output holds the previous write
    cmd_fifo_full = 1'b1;
    send_pkt(CMD_WRITE, 8'h05, 8'h77);
    chk("t3_overflows", ov_cnt, 32'd1);
    chk("t3_no_write", wr_cnt, 32'd3);
    chk("t3_data_held", {8'd0, cmd_wr_data}, 32'h012000);
    cmd_fifo_full = 1'b0;
    send_pkt(CMD_READ, 8'h05, 8'h00);
    chk("t3_data", {8'd0, cmd_wr_data}, 32'h010500);

    // timeout: 512 ticks after the stop sample of the partial packet's last byte
    send(CMD_WRITE, 1'b1, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    m_timeout();
    ticks(504);
    @(negedge clk);
    chk("t4_no_early_timeout", {31'd0, timeout_err}, 32'd0);
    ticks(1);
    @(negedge clk);
    chk("t4_timeout_pulse", {31'd0, timeout_err}, 32'd1);
    ticks(16);
    chk("t4_timeouts", to_cnt, 32'd1);
    send_pkt(CMD_READ, 8'h33, 8'h00);
    chk("t4_data", {8'd0, cmd_wr_data}, 32'h013300);

    // reset asserted during data bit 4 of 0x5A
    rbyte = 8'h5A;
    rx = 1'b0; ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = rbyte[i];
      ticks(16);
    end
    rx = rbyte[4];
    ticks(5);
    rst = 1'b0;
    #1;
    chk("t5_rst_wr_data", {8'd0, cmd_wr_data}, 32'd0);
    chk("t5_rst_pulses", {28'd0, cmd_wr_en, frame_err, overflow_err, timeout_err}, 32'd0);
    m_idx = 0;
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    ticks(4);
    send_pkt(CMD_WRITE, 8'hFF, 8'h81);
    chk("t5_data", {8'd0, cmd_wr_data}, 32'h02FF81);

    // four back-to-back packets, no idle between stop and start
    b2b = '{CMD_WRITE, 8'h11, 8'h22, CMD_READ, 8'h33, 8'h44,
            CMD_WRITE, 8'h55, 8'h66, CMD_READ, 8'h77, 8'h88};
    w0 = wr_cnt;
    for (int i = 0; i < 12; i++) send(b2b[i], 1'b1, 1'b0);
    chk("t6_writes", wr_cnt - w0, 32'd4);
    chk("t6_last_data", {8'd0, cmd_wr_data}, 32'h017788);

    ticks(4);
    chk("events_drained", exp_q.size(), 32'd0);
    chk("frame_errs_total", fe_cnt, 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
